// File: rtl/wb_macro_arbiter_pkg.sv
// wb_arb_pkg: shared types and constants for the Wishbone macro arbiter.
//   arb_state_t : transaction FSM states (IDLE / WAIT / ACK)
//   SLOT_INT    : address slot that selects the internal register bank
//   REG_*       : word offsets (wbs_adr_i[3:2]) inside the register bank
//   TO_DATA     : read data returned when a macro never acknowledges
//   sat_inc8    : saturating 8-bit increment used by the timeout counter
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } arb_state_t;

  localparam logic [3:0]  SLOT_INT   = 4'hF;
  localparam logic [1:0]  REG_IO_SEL = 2'd0;
  localparam logic [1:0]  REG_STATUS = 2'd1;
  localparam logic [31:0] TO_DATA    = 32'hDEADBEEF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wb_macro_arbiter_if.sv
// wb_macro_arbiter_if: host-side Wishbone slave bus of the arbiter.
//   master modport : driven by the management SoC (request fields), receives ack/data
//   slave  modport : used by wb_macro_arbiter
// Signal names keep the SoC's wbs_* naming, with _i/_o seen from the arbiter.
interface wb_macro_arbiter_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_macro_arbiter_io_owner_mux.sv
// io_owner_mux: picks which macro drives the GPIO pads.
//   i_sel              : owner index (IO_SEL register)
//   i_io_out/i_io_oeb  : IO_W-bit slices per macro, slot k at [IO_W*k +: IO_W]
//   o_io_out/o_io_oeb  : pad drive/enable; an out-of-range owner leaves the
//                        pads as inputs (out = 0, oeb = all ones)
module io_owner_mux #(
  parameter int N_MACRO = 3,
  parameter int IO_W    = 38
) (
  input  logic [3:0]              i_sel,
  input  logic [IO_W*N_MACRO-1:0] i_io_out,
  input  logic [IO_W*N_MACRO-1:0] i_io_oeb,
  output logic [IO_W-1:0]         o_io_out,
  output logic [IO_W-1:0]         o_io_oeb
);

  always_comb begin
    o_io_out = '0;
    o_io_oeb = '1;
    for (int k = 0; k < N_MACRO; k++) begin
      if (i_sel == 4'(k)) begin
        o_io_out = i_io_out[k*IO_W +: IO_W];
        o_io_oeb = i_io_oeb[k*IO_W +: IO_W];
      end
    end
  end

endmodule

// File: rtl/wb_macro_arbiter.sv
// wb_macro_arbiter: routes each host Wishbone access to exactly one user macro
// slot, the internal register bank, or the UNMAPPED responder, with a single
// outstanding transaction and a per-access timeout.
//   wb_clk_i / wb_rst_i      : clock, synchronous active-high reset
//   wbs                      : host Wishbone bus (slave modport)
//   m_cyc_o/m_stb_o          : per-slot cycle/strobe, one-hot or zero
//   m_we_o/m_sel_o/m_adr_o/m_dat_o : registered copies of the host request
//   m_ack_i/m_dat_i          : per-slot ack and read data (slot k at [32k +: 32])
//   m_io_out_i/m_io_oeb_i    : per-macro GPIO drive/enable
//   io_out/io_oeb            : GPIO of the macro selected by IO_SEL
module wb_macro_arbiter
  import wb_arb_pkg::*;
#(
  parameter int          N_MACRO = 3,
  parameter int          IO_W    = 38,
  parameter logic [7:0]  BASE_HI = 8'h30,
  parameter int          TIMEOUT = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  wb_macro_arbiter_if.slave       wbs,
  output logic [N_MACRO-1:0]      m_cyc_o,
  output logic [N_MACRO-1:0]      m_stb_o,
  output logic                    m_we_o,
  output logic [3:0]              m_sel_o,
  output logic [31:0]             m_adr_o,
  output logic [31:0]             m_dat_o,
  input  logic [N_MACRO-1:0]      m_ack_i,
  input  logic [32*N_MACRO-1:0]   m_dat_i,
  input  logic [IO_W*N_MACRO-1:0] m_io_out_i,
  input  logic [IO_W*N_MACRO-1:0] m_io_oeb_i,
  output logic [IO_W-1:0]         io_out,
  output logic [IO_W-1:0]         io_oeb
);

  localparam logic [3:0] NM     = 4'(N_MACRO);
  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  arb_state_t  r_state, w_state_nxt;
  logic [3:0]  r_slot, r_io_sel, r_to_slot;
  logic [7:0]  r_to_cnt, r_tmr;
  logic        r_ack;
  logic [31:0] r_dat;

  logic        w_req, w_hit, w_is_int, w_is_mac, w_timeout, w_ack_sel;
  logic [3:0]  w_slot;
  logic [31:0] w_mdat_sel, w_reg_rd;

  assign w_req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign w_slot    = wbs.wbs_adr_i[23:20];
  assign w_hit     = (wbs.wbs_adr_i[31:24] == BASE_HI);
  assign w_is_int  = w_hit && (w_slot == SLOT_INT);
  assign w_is_mac  = w_hit && (w_slot < NM);
  assign w_timeout = (r_tmr == TO_MAX);

  assign wbs.wbs_ack_o = r_ack;
  assign wbs.wbs_dat_o = r_dat;

  // Only the latched slot's ack/data are visible; other slots are ignored.
  always_comb begin
    w_ack_sel  = 1'b0;
    w_mdat_sel = '0;
    for (int k = 0; k < N_MACRO; k++) begin
      if (r_slot == 4'(k)) begin
        w_ack_sel  = m_ack_i[k];
        w_mdat_sel = m_dat_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    unique case (wbs.wbs_adr_i[3:2])
      REG_IO_SEL: w_reg_rd = {28'd0, r_io_sel};
      REG_STATUS: w_reg_rd = {20'd0, r_to_slot, r_to_cnt};
      default:    w_reg_rd = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state; a host abort beats a same-cycle macro ack
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req) w_state_nxt = w_is_mac ? ST_WAIT : ST_ACK;
      ST_WAIT: begin
        if (!wbs.wbs_cyc_i)           w_state_nxt = ST_IDLE;
        else if (w_ack_sel || w_timeout) w_state_nxt = ST_ACK;
      end
      ST_ACK:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: the slot strobes exist only while waiting on a macro
  always_comb begin
    m_cyc_o = '0;
    m_stb_o = '0;
    if (r_state == ST_WAIT) begin
      for (int k = 0; k < N_MACRO; k++) begin
        m_cyc_o[k] = (r_slot == 4'(k));
        m_stb_o[k] = (r_slot == 4'(k));
      end
    end
  end

  // Request latch, timeout counter, response data and register bank
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_slot    <= '0;
      r_tmr     <= '0;
      r_io_sel  <= '0;
      r_to_cnt  <= '0;
      r_to_slot <= '0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
    end else begin
      r_ack <= (w_state_nxt == ST_ACK);
      unique case (r_state)
        ST_IDLE: if (w_req) begin
          r_slot <= w_slot;
          r_tmr  <= '0;
          if (w_is_mac) begin
            m_we_o  <= wbs.wbs_we_i;
            m_sel_o <= wbs.wbs_sel_i;
            m_adr_o <= wbs.wbs_adr_i;
            m_dat_o <= wbs.wbs_dat_i;
          end else if (w_is_int) begin
            r_dat <= wbs.wbs_we_i ? 32'd0 : w_reg_rd;
            if (wbs.wbs_we_i && wbs.wbs_sel_i[0] && (wbs.wbs_adr_i[3:2] == REG_IO_SEL))
              r_io_sel <= wbs.wbs_dat_i[3:0];
          end else begin
            r_dat <= '0;
          end
        end
        ST_WAIT: if (wbs.wbs_cyc_i) begin
          if (w_ack_sel) begin
            r_dat <= w_mdat_sel;
          end else if (w_timeout) begin
            r_dat     <= TO_DATA;
            r_to_cnt  <= sat_inc8(r_to_cnt);
            r_to_slot <= r_slot;
          end else begin
            r_tmr <= r_tmr + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  io_owner_mux #(
    .N_MACRO (N_MACRO),
    .IO_W    (IO_W)
  ) u_io_mux (
    .i_sel    (r_io_sel),
    .i_io_out (m_io_out_i),
    .i_io_oeb (m_io_oeb_i),
    .o_io_out (io_out),
    .o_io_oeb (io_oeb)
  );

endmodule

// File: doc/wb_macro_arbiter.md
# wb_macro_arbiter

Sits between the management-SoC Wishbone slave port and the user macros inside `user_project_wrapper`. It replaces the direct shared fan-out of `wbs_*`, `io_out` and `io_oeb` with a proper owner per transaction. Each Wishbone access is address-decoded to exactly one macro slot, sequenced through a one-outstanding-transaction FSM with a timeout, and acknowledged back to the host. A small internal register bank selects which macro owns the GPIO outputs.

## Interface
Parameters:
- `N_MACRO`, 3: number of macro slots (max 15).
- `IO_W`, 38: GPIO width (`MPRJ_IO_PADS`).
- `BASE_HI`, 8'h30: required value of `wbs_adr_i[31:24]`.
- `TIMEOUT`, 255: maximum cycles to wait for a macro ack (1..255).

Ports:
- `wb_clk_i`  in  1  the only clock.
- `wb_rst_i`  in  1  synchronous, active-high reset.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`  in  1 each  host Wishbone strobe, cycle, write enable.
- `wbs_sel_i`  in  4  host byte lane selects.
- `wbs_adr_i`, `wbs_dat_i`  in  32 each  host address and write data.
- `wbs_ack_o`  out  1  host acknowledge (registered).
- `wbs_dat_o`  out  32  host read data (registered).
- `m_cyc_o`, `m_stb_o`  out  N_MACRO each  per-slot cycle and strobe (one-hot or zero).
- `m_we_o`, `m_sel_o`, `m_adr_o`, `m_dat_o`  out  1/4/32/32  shared request fields, registered copies of the host request.
- `m_ack_i`  in  N_MACRO  per-slot ack.
- `m_dat_i`  in  32*N_MACRO  per-slot read data; slot k occupies bits [32k+31:32k].
- `m_io_out_i`, `m_io_oeb_i`  in  IO_W*N_MACRO each  per-macro GPIO drive and enable.
- `io_out`, `io_oeb`  out  IO_W each  GPIO drive and enable of the selected owner.

## Operation
- Decode when `wbs_cyc_i & wbs_stb_i` are both high in IDLE. The slot is `s = wbs_adr_i[23:20]`.
  - `wbs_adr_i[31:24] != BASE_HI`, or `N_MACRO <= s < 15`: UNMAPPED.
  - `s == 15`: internal registers.
  - Otherwise: macro slot `s`.
- FSM states: IDLE, WAIT, ACK.
  - IDLE → WAIT on a macro request: latch `m_*` fields, assert `m_cyc_o[s]` and `m_stb_o[s]`, clear the timeout counter.
  - IDLE → ACK on an internal or UNMAPPED request. UNMAPPED reads return 0 and UNMAPPED writes are dropped.
  - WAIT → ACK on `m_ack_i[s]`: capture `m_dat_i` slot `s`, drop `m_cyc_o` and `m_stb_o`.
  - WAIT → ACK when the counter reaches TIMEOUT: drop `m_cyc_o` and `m_stb_o`, return 32'hDEADBEEF, increment TO_CNT, set TO_SLOT = `s`.
  - WAIT → IDLE when `wbs_cyc_i` falls (host abort): drop `m_cyc_o` and `m_stb_o`, no ack.
  - ACK → IDLE unconditionally. `wbs_ack_o` is high only in ACK.
- Ack and timeout in the same cycle: the ack wins; TO_CNT is unchanged.
- `m_ack_i` bits for slots other than `s`, and any `m_ack_i` outside WAIT, are ignored.
- Internal registers, selected by `wbs_adr_i[3:2]`:
  - 0 `IO_SEL`: RW in bits [3:0]. A write takes effect only when `wbs_sel_i[0]` is high.
  - 1 `STATUS`: RO. `[7:0]` TO_CNT (saturates at 255), `[11:8]` TO_SLOT.
  - 2 and 3: read 0, writes ignored.
- GPIO mux:
  - `IO_SEL < N_MACRO`: `io_out` and `io_oeb` are the selected slice.
  - Otherwise: `io_out = 0` and `io_oeb` = all ones (pads input).
  - The mux is combinational from the `IO_SEL` register.

## Timing
- Reset values, applied on the first clock edge with `wb_rst_i` high:
  - FSM in IDLE; `wbs_ack_o = 0`, `wbs_dat_o = 0`.
  - All `m_cyc_o` and `m_stb_o` = 0; `m_we_o`, `m_sel_o`, `m_adr_o`, `m_dat_o` = 0.
  - `IO_SEL = 0`, so `io_out`/`io_oeb` follow macro 0; TO_CNT = 0, TO_SLOT = 0.
- Reset mid-transaction aborts it silently: no ack, and the macro strobes drop in the next cycle.
- Internal/UNMAPPED latency: request sampled at edge 0, `wbs_ack_o` high in cycle 1 for exactly one cycle. An `IO_SEL` write is visible on `io_*` in cycle 1.
- Macro latency:
  - `m_stb_o[s]` is high from cycle 1.
  - A macro ack sampled in cycle k gives `wbs_ack_o` in cycle k+1. The minimum total is 2 cycles.
- Timeout: with no ack, `wbs_ack_o` rises TIMEOUT+1 cycles after `m_stb_o` rose.
- The host must drop `stb` after sampling ack. Because ACK always returns to IDLE, a held `stb` starts a new transaction.

## Structure
- Package `wb_arb_pkg` holds:
  - FSM state enum.
  - `SLOT_INT = 4'hF`.
  - Register offsets `REG_IO_SEL` and `REG_STATUS`.
  - `TO_DATA = 32'hDEADBEEF`.
- Sub-module `io_owner_mux`: parameterised `N_MACRO` × `IO_W` combinational selector with the safe default for out-of-range selects.
- FSM, timeout counter and register bank stay in the top module.

## Test plan
- Read slot 1: address 0x3010_0000, macro 1 acks 3 cycles after `stb` with 0x1234_5678 → `wbs_dat_o = 0x12345678`, ack one cycle later, only `m_stb_o[1]` ever high.
- Timeout: read slot 2 with no ack → ack after TIMEOUT+1 cycles, data 0xDEADBEEF, STATUS reads 0x0000_0201.
- Write `IO_SEL = 2` at 0x30F0_0000 with sel = 4'b0001 → ack in 1 cycle, `io_out` follows macro 2 from cycle 1. `IO_SEL = 7` → `io_oeb` all ones, `io_out = 0`.
- UNMAPPED: address 0x3040_0000 with N_MACRO = 3, and 0x2000_0000 → ack in 1 cycle, read 0, no `m_stb_o` asserted.
- Host abort: drop `cyc` in WAIT → `m_stb_o` low the next cycle, no ack. Then a late `m_ack_i` → ignored, and the FSM accepts a new request.
- Reset during WAIT → all outputs at reset values on the next edge; TO_CNT saturation checked with 256 timeouts → 255.
